hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline hazard and multi-cycle sequencing controller for the 5-stage core (fetch/decode/execute/memory/writeback).
//  Detects load-use hazards, sequences the multi-cycle mult/div unit with a start/wait/release FSM,
//  and flushes the wrong-path instructions on a taken branch or jump resolved in execute.
//  Drives PC/latch enables and bubble insertion; sits beside the pipeline latches in the processor top.
// PARAMETERS
//  MD_TIMEOUT  40  max cycles in MD_WAIT before forced release with md_timeout
//  CNT_W       6   width of the wait counter; must satisfy 2**CNT_W > MD_TIMEOUT
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-low; 0 at a rising edge resets all state
//  fd_rs          in   5   source reg A of the instruction in the F/D latch
//  fd_rt          in   5   source reg B of the instruction in the F/D latch
//  fd_uses_rt     in   1   F/D instruction reads rt
//  dx_rd          in   5   destination reg of the instruction in the D/X latch
//  dx_is_load     in   1   D/X instruction is lw
//  dx_is_mult     in   1   D/X instruction is mul
//  dx_is_div      in   1   D/X instruction is div
//  x_redirect     in   1   execute resolved a taken branch or jump this cycle
//  md_ready       in   1   mult/div result valid (one-cycle pulse from the unit)
//  md_exception   in   1   mult/div error, sampled with md_ready
//  pc_en          out  1   PC register write enable
//  fd_en          out  1   F/D latch write enable
//  dx_bubble      out  1   load a nop into D/X this cycle
//  fd_flush       out  1   load a nop into F/D this cycle
//  xm_bubble      out  1   load a nop into X/M (mult/div still busy)
//  md_ctrl_mult   out  1   one-cycle start pulse to the multiplier
//  md_ctrl_div    out  1   one-cycle start pulse to the divider
//  md_release     out  1   one cycle; the mult/div result goes into X/M this cycle
//  md_timeout     out  1   sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0 at edge): FSM=MD_IDLE, counter=0, md_timeout=0, load_stall_q=0.
//  Outputs are combinational from state plus inputs. While reset=0 they are forced to:
//  pc_en=1, fd_en=1, all bubble/flush/pulse outputs=0.
//  FSM states: MD_IDLE, MD_WAIT, MD_RELEASE.
//   MD_IDLE:    if dx_is_mult|dx_is_div then assert md_ctrl_mult or md_ctrl_div for this cycle and go to MD_WAIT.
//               The instruction is held in D/X (pc_en=0, fd_en=0, xm_bubble=1).
//               If both flags are set, mult wins.
//   MD_WAIT:    pc_en=0, fd_en=0, xm_bubble=1, counter+=1.
//               md_ready=1 -> MD_RELEASE.
//               Else if counter==MD_TIMEOUT-1 -> set md_timeout, go to MD_RELEASE.
//               No start pulse is re-issued.
//   MD_RELEASE: md_release=1, pc_en=1, fd_en=1, dx_bubble=1, counter cleared, go to MD_IDLE.
//               dx_bubble=1 prevents a restart from the same D/X contents.
//  Load-use: hazard = dx_is_load & dx_rd!=0 & (fd_rs==dx_rd | fd_uses_rt & fd_rt==dx_rd).
//   On a hazard: pc_en=0, fd_en=0, dx_bubble=1 for exactly one cycle.
//   load_stall_q is registered so the stall cannot repeat for the same pair
//   (the bubble clears dx_is_load next cycle).
//  Redirect: x_redirect=1 -> fd_flush=1 and dx_bubble=1 in the same cycle, pc_en=1.
//  Priority when events coincide: reset > MD_WAIT/start hold > MD_RELEASE > x_redirect > load-use.
//   x_redirect while the FSM is not MD_IDLE is ignored. It cannot be legal, because the mult/div op occupies execute.
//   A load-use hazard in MD_RELEASE is deferred one cycle.
//  Register $0 never causes a hazard.
//  md_ready in MD_IDLE is ignored. md_exception is passed through by the datapath and does not change FSM flow.
//  Reset mid-MD_WAIT: the FSM returns to MD_IDLE next edge, with no md_release and no pulse.
//  The counter saturates; it never wraps.
// TESTING
//  1. reset=0 for 2 cycles -> pc_en=1, fd_en=1, all others 0; after release, state=MD_IDLE.
//  2. dx_is_mult=1, md_ready pulsed 16 cycles after the start -> md_ctrl_mult high for 1 cycle,
//     pc_en low for 17 cycles, then md_release for 1 cycle with dx_bubble=1.
//  3. dx_is_load=1, dx_rd=5, fd_rs=5 -> exactly 1 stall cycle (pc_en=0, dx_bubble=1).
//     Repeat with dx_rd=0 -> no stall.
//  4. x_redirect=1 with a load-use hazard present -> fd_flush=1, dx_bubble=1, pc_en=1 (the flush wins).
//  5. dx_is_div=1 with md_ready never asserted -> release on wait cycle 40.
//     md_timeout stays set until reset=0.
//  6. reset=0 asserted on wait cycle 5 of a divide -> MD_IDLE next cycle, md_release never asserted.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Hazard and multi-cycle sequencing controller for the 5-stage core.
// Outputs are combinational from state and inputs; state changes on core clock edges.
module hazard_sequencer #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [4:0] i_fd_rs,
  input  logic [4:0] i_fd_rt,
  input  logic       i_fd_uses_rt,
  input  logic [4:0] i_dx_rd,
  input  logic       i_dx_is_load,
  input  logic       i_dx_is_mult,
  input  logic       i_dx_is_div,
  input  logic       i_x_redirect,
  input  logic       i_md_ready,
  input  logic       i_md_exception,
  output logic       o_pc_en,
  output logic       o_fd_en,
  output logic       o_dx_bubble,
  output logic       o_fd_flush,
  output logic       o_xm_bubble,
  output logic       o_md_ctrl_mult,
  output logic       o_md_ctrl_div,
  output logic       o_md_release,
  output logic       o_md_timeout
);

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_WAIT    = 2'd1,
    MD_RELEASE = 2'd2
  } md_state_t;

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_md_timeout, w_md_timeout_nxt;
  logic             r_load_stall_q, w_load_stall;
  logic             w_hazard;
  logic             w_unused_exception;

  // The exception travels with the result through the datapath; it never steers the FSM.
  assign w_unused_exception = i_md_exception;

  assign w_hazard = i_dx_is_load & (i_dx_rd != 5'd0) &
                    ((i_fd_rs == i_dx_rd) | (i_fd_uses_rt & (i_fd_rt == i_dx_rd)));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state        <= MD_IDLE;
      r_cnt          <= '0;
      r_md_timeout   <= 1'b0;
      r_load_stall_q <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_md_timeout   <= w_md_timeout_nxt;
      r_load_stall_q <= w_load_stall;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_md_timeout_nxt = r_md_timeout;
    w_load_stall     = 1'b0;
    o_pc_en          = 1'b1;
    o_fd_en          = 1'b1;
    o_dx_bubble      = 1'b0;
    o_fd_flush       = 1'b0;
    o_xm_bubble      = 1'b0;
    o_md_ctrl_mult   = 1'b0;
    o_md_ctrl_div    = 1'b0;
    o_md_release     = 1'b0;

    if (!i_reset) begin
      w_state_nxt      = MD_IDLE;
      w_cnt_nxt        = '0;
      w_md_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_dx_is_mult | i_dx_is_div) begin
            o_md_ctrl_mult = i_dx_is_mult;
            o_md_ctrl_div  = ~i_dx_is_mult & i_dx_is_div;
            o_pc_en        = 1'b0;
            o_fd_en        = 1'b0;
            o_xm_bubble    = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = MD_WAIT;
          end else if (i_x_redirect) begin
            o_fd_flush  = 1'b1;
            o_dx_bubble = 1'b1;
          end else if (w_hazard & ~r_load_stall_q) begin
            // One-shot: the bubble clears dx_is_load, and r_load_stall_q guards the same pair.
            o_pc_en      = 1'b0;
            o_fd_en      = 1'b0;
            o_dx_bubble  = 1'b1;
            w_load_stall = 1'b1;
          end
        end
        MD_WAIT: begin
          o_pc_en     = 1'b0;
          o_fd_en     = 1'b0;
          o_xm_bubble = 1'b1;
          if (r_cnt != {CNT_W{1'b1}}) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          if (i_md_ready) begin
            w_state_nxt = MD_RELEASE;
          end else if (r_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
            w_md_timeout_nxt = 1'b1;
            w_state_nxt      = MD_RELEASE;
          end
        end
        MD_RELEASE: begin
          // Bubble into D/X so the same mult/div op is not restarted.
          o_md_release = 1'b1;
          o_dx_bubble  = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = MD_IDLE;
        end
        default: begin
          w_state_nxt = MD_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_md_timeout = r_md_timeout & i_reset;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized and directed stimulus against a cycle-level reference model; a monitor pops expectations.
module tb_hazard_sequencer;
  localparam int MD_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] fd_rs = '0, fd_rt = '0, dx_rd = '0;
  logic       fd_uses_rt = 1'b0, dx_is_load = 1'b0, dx_is_mult = 1'b0, dx_is_div = 1'b0;
  logic       x_redirect = 1'b0, md_ready = 1'b0, md_exception = 1'b0;
  logic       pc_en, fd_en, dx_bubble, fd_flush, xm_bubble;
  logic       md_ctrl_mult, md_ctrl_div, md_release, md_timeout;

  hazard_sequencer #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(6)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_fd_rs(fd_rs), .i_fd_rt(fd_rt), .i_fd_uses_rt(fd_uses_rt),
    .i_dx_rd(dx_rd), .i_dx_is_load(dx_is_load), .i_dx_is_mult(dx_is_mult), .i_dx_is_div(dx_is_div),
    .i_x_redirect(x_redirect), .i_md_ready(md_ready), .i_md_exception(md_exception),
    .o_pc_en(pc_en), .o_fd_en(fd_en), .o_dx_bubble(dx_bubble), .o_fd_flush(fd_flush),
    .o_xm_bubble(xm_bubble), .o_md_ctrl_mult(md_ctrl_mult), .o_md_ctrl_div(md_ctrl_div),
    .o_md_release(md_release), .o_md_timeout(md_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] outs;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int unsigned cyc_n = 0;

  // Reference model: mult/div occupancy measured in wait cycles, plus sticky flags.
  bit m_busy = 0;
  bit m_release_due = 0;
  bit m_timeout = 0;
  bit m_stalled_last = 0;
  int m_waited = 0;

  task automatic model_step();
    bit pc, fe, db, ff, xb, cm, cd, rl, hz, stall;
    pc = 1; fe = 1; db = 0; ff = 0; xb = 0; cm = 0; cd = 0; rl = 0; stall = 0;
    hz = dx_is_load && dx_rd != 0 && (fd_rs == dx_rd || (fd_uses_rt && fd_rt == dx_rd));
    exp_q.push_back('{outs: {pc, fe, db, ff, xb, cm, cd, rl, 1'b0}, cyc: cyc_n});
    if (!rst_n) begin
      m_busy = 0; m_release_due = 0; m_timeout = 0; m_waited = 0;
    end else if (m_release_due) begin
      rl = 1; db = 1; m_release_due = 0;
    end else if (m_busy) begin
      pc = 0; fe = 0; xb = 1;
      m_waited++;
      if (md_ready || m_waited == MD_TIMEOUT) begin
        if (!md_ready) m_timeout = 1;
        m_busy = 0; m_release_due = 1;
      end
    end else if (dx_is_mult || dx_is_div) begin
      pc = 0; fe = 0; xb = 1; cm = dx_is_mult; cd = !dx_is_mult;
      m_busy = 1; m_waited = 0;
    end else if (x_redirect) begin
      ff = 1; db = 1;
    end else if (hz && !m_stalled_last) begin
      pc = 0; fe = 0; db = 1; stall = 1;
    end
    m_stalled_last = rst_n ? stall : 0;
    exp_q[exp_q.size()-1].outs = {pc, fe, db, ff, xb, cm, cd, rl, 1'b0};
  endtask

  task automatic drive(input bit rst, input int rs, input int rt, input bit urt, input int rd,
                       input bit ld, input bit mul, input bit dv, input bit redir, input bit rdy);
    bit cur_to;
    @(posedge clk); #1;
    cyc_n++;
    rst_n = rst; fd_rs = rs[4:0]; fd_rt = rt[4:0]; fd_uses_rt = urt; dx_rd = rd[4:0];
    dx_is_load = ld; dx_is_mult = mul; dx_is_div = dv; x_redirect = redir; md_ready = rdy;
    md_exception = rdy & ($urandom_range(0, 3) == 0);
    cur_to = m_timeout & rst;
    model_step();
    exp_q[exp_q.size()-1].outs[0] = cur_to;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = exp_q.pop_front();
      act = {pc_en, fd_en, dx_bubble, fd_flush, xm_bubble, md_ctrl_mult, md_ctrl_div, md_release, md_timeout};
      checks++;
      if (act !== e.outs) begin
        failures++;
        $display("FAIL outputs cycle=%0d {pc,fd,dxb,flush,xmb,mul,div,rel,to} actual=%b required=%b",
                 e.cyc, act, e.outs);
      end
    end
  end

  initial begin
    // Reset held low for two cycles.
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Multiply: md_ready arrives 16 cycles after the start pulse.
    drive(1, 1, 2, 1, 3, 0, 1, 0, 0, 0);
    for (int i = 1; i < 16; i++) drive(1, 1, 2, 1, 3, 0, 1, 0, 0, 0);
    drive(1, 1, 2, 1, 3, 0, 1, 0, 0, 1);
    drive(1, 1, 2, 1, 3, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs, then the bubble clears the load; then the $0 case.
    drive(1, 5, 7, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 5, 7, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 6, 9, 1, 9, 1, 0, 0, 0, 0);
    drive(1, 6, 9, 1, 9, 1, 0, 0, 0, 0);
    // Redirect coinciding with a load-use hazard.
    drive(1, 5, 7, 0, 5, 1, 0, 0, 1, 0);
    // Divide that never completes: forced release with the timeout flag.
    for (int i = 0; i < MD_TIMEOUT + 1; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset on wait cycle 5 of a divide.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 149) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
